// File: rtl/mul4_tournament_sequencer.sv
// mul4_tournament_sequencer
//
// Runs a tournament across NUM_CAND candidate 2x2-bit multipliers. All candidates
// share one combinational datapath. Each candidate in turn is selected through
// cand_sel and given the exhaustive 16-lane operand vector. The sequencer waits
// SETTLE_CYCLES, captures the result lanes and scores them against the golden
// product. It keeps the best (candidate index, score) pair.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, abort            launch a tournament (IDLE only) / cancel one in flight
//   cand_mask [NUM_CAND]    participating candidates, latched at start
//   cand_sel                candidate currently driven to the datapath
//   a1, a0, b1, b0 [16]     operand lanes (lane i: a = i[3:2], b = i[1:0])
//   y3, y2, y1, y0 [16]     result lanes returned by the selected candidate
//   busy                    tournament in progress
//   score_valid/score/score_idx   one-cycle per-candidate score report
//   done                    one-cycle completion pulse
//   winner_valid/winner/winner_score   best candidate, held until next start

module mul4_tournament_sequencer #(
    parameter int NUM_CAND      = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_CAND-1:0]         cand_mask,
    output logic [$clog2(NUM_CAND)-1:0] cand_sel,
    output logic [15:0]                 a1,
    output logic [15:0]                 a0,
    output logic [15:0]                 b1,
    output logic [15:0]                 b0,
    input  logic [15:0]                 y3,
    input  logic [15:0]                 y2,
    input  logic [15:0]                 y1,
    input  logic [15:0]                 y0,
    output logic                        busy,
    output logic                        score_valid,
    output logic [6:0]                  score,
    output logic [$clog2(NUM_CAND)-1:0] score_idx,
    output logic                        done,
    output logic                        winner_valid,
    output logic [$clog2(NUM_CAND)-1:0] winner,
    output logic [6:0]                  winner_score
);

    localparam int SEL_W = $clog2(NUM_CAND);

    // Exhaustive operand vector and its golden product, one lane per (a,b) pair.
    localparam logic [15:0] VEC_A1 = 16'hFF00;
    localparam logic [15:0] VEC_A0 = 16'hF0F0;
    localparam logic [15:0] VEC_B1 = 16'hCCCC;
    localparam logic [15:0] VEC_B0 = 16'hAAAA;
    localparam logic [15:0] GOLD_3 = 16'h8000;
    localparam logic [15:0] GOLD_2 = 16'h4C00;
    localparam logic [15:0] GOLD_1 = 16'h6AC0;
    localparam logic [15:0] GOLD_0 = 16'hA0A0;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, SCORE, DONE} state_t;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic [NUM_CAND-1:0] mask_reg;
    logic [15:0]         cap_y3_reg, cap_y2_reg, cap_y1_reg, cap_y0_reg;

    logic [SEL_W-1:0]    first_idx;
    logic [SEL_W-1:0]    next_idx;
    logic                next_found;
    logic [15:0][2:0]    lane_cnt;
    logic [6:0]          score_calc;

    // Lowest participating candidate in the incoming mask. The scan runs downward,
    // so the last hit is the lowest index.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (cand_mask[i]) begin
                first_idx = SEL_W'(i);
            end
        end
    end

    // Next participating candidate strictly above the current one.
    always_comb begin
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (mask_reg[i] && (SEL_W'(i) > cand_sel)) begin
                next_idx   = SEL_W'(i);
                next_found = 1'b1;
            end
        end
    end

    // Correct output bits per lane (0..4), then summed over all 16 lanes (0..64).
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_lane
            assign lane_cnt[gi] = 3'(~(cap_y3_reg[gi] ^ GOLD_3[gi]))
                                + 3'(~(cap_y2_reg[gi] ^ GOLD_2[gi]))
                                + 3'(~(cap_y1_reg[gi] ^ GOLD_1[gi]))
                                + 3'(~(cap_y0_reg[gi] ^ GOLD_0[gi]));
        end
    endgenerate

    always_comb begin
        score_calc = '0;
        for (int i = 0; i < 16; i++) begin
            score_calc = score_calc + 7'(lane_cnt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            mask_reg     <= '0;
            cap_y3_reg   <= '0;
            cap_y2_reg   <= '0;
            cap_y1_reg   <= '0;
            cap_y0_reg   <= '0;
            cand_sel     <= '0;
            a1           <= '0;
            a0           <= '0;
            b1           <= '0;
            b0           <= '0;
            busy         <= 1'b0;
            score_valid  <= 1'b0;
            score        <= '0;
            score_idx    <= '0;
            done         <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= '0;
            winner_score <= '0;
        end else begin
            score_valid <= 1'b0;
            done        <= 1'b0;

            if ((state_reg != IDLE) && abort) begin
                // Abort discards the tournament. No done and no score report
                // this cycle, and the partial winner is invalidated.
                state_reg    <= IDLE;
                busy         <= 1'b0;
                winner_valid <= 1'b0;
                cnt_reg      <= '0;
                a1           <= '0;
                a0           <= '0;
                b1           <= '0;
                b0           <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        // abort wins over a simultaneous start
                        if (start && !abort) begin
                            mask_reg     <= cand_mask;
                            winner_valid <= 1'b0;
                            winner       <= '0;
                            winner_score <= '0;
                            a1           <= VEC_A1;
                            a0           <= VEC_A0;
                            b1           <= VEC_B1;
                            b0           <= VEC_B0;
                            if (cand_mask == '0) begin
                                busy      <= 1'b0;
                                state_reg <= DONE;
                            end else begin
                                busy      <= 1'b1;
                                cand_sel  <= first_idx;
                                cnt_reg   <= '0;
                                state_reg <= SETTLE;
                            end
                        end
                    end

                    SETTLE: begin
                        cnt_reg <= cnt_reg + 4'd1;
                        if (cnt_reg == SETTLE_LAST) begin
                            state_reg <= CAPTURE;
                        end
                    end

                    CAPTURE: begin
                        cap_y3_reg <= y3;
                        cap_y2_reg <= y2;
                        cap_y1_reg <= y1;
                        cap_y0_reg <= y0;
                        state_reg  <= SCORE;
                    end

                    SCORE: begin
                        score       <= score_calc;
                        score_idx   <= cand_sel;
                        score_valid <= 1'b1;
                        // Strict compare: on a tie the earlier (lower) index is kept.
                        if (!winner_valid || (score_calc > winner_score)) begin
                            winner       <= cand_sel;
                            winner_score <= score_calc;
                            winner_valid <= 1'b1;
                        end
                        if (next_found) begin
                            cand_sel  <= next_idx;
                            cnt_reg   <= '0;
                            state_reg <= SETTLE;
                        end else begin
                            busy      <= 1'b0;
                            state_reg <= DONE;
                        end
                    end

                    DONE: begin
                        done      <= 1'b1;
                        state_reg <= IDLE;
                        a1        <= '0;
                        a0        <= '0;
                        b1        <= '0;
                        b0        <= '0;
                    end

                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul4_tournament_sequencer.sv
// Testbench for mul4_tournament_sequencer (NUM_CAND=8, SETTLE_CYCLES=2).
// The bench models the candidate multiplexer: the y lanes come from per-slot
// tables indexed by cand_sel. When a tournament is launched, the expected
// (index, score) reports are queued. A negedge monitor pops the queue and
// compares each entry whenever score_valid is high.
//
// Golden lanes: y3=8000 y2=4C00 y1=6AC0 y0=A0A0 hold 1+3+6+4 = 14 ones.
// An all-zero candidate therefore scores 64-14 = 50. A golden candidate whose
// y0 has its low 4 bits flipped scores 60.

module tb_mul4_tournament_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cand_mask = '0;
    logic [2:0]  cand_sel;
    logic [15:0] a1, a0, b1, b0;
    logic [15:0] y3, y2, y1, y0;
    logic        busy, score_valid, done, winner_valid;
    logic [6:0]  score, winner_score;
    logic [2:0]  score_idx, winner;

    logic [15:0] s_y3 [8];
    logic [15:0] s_y2 [8];
    logic [15:0] s_y1 [8];
    logic [15:0] s_y0 [8];
    logic [6:0]  exp_sc [8];

    typedef struct packed {
        logic [2:0] idx;
        logic [6:0] sc;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign y3 = s_y3[cand_sel];
    assign y2 = s_y2[cand_sel];
    assign y1 = s_y1[cand_sel];
    assign y0 = s_y0[cand_sel];

    mul4_tournament_sequencer #(.NUM_CAND(8), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cand_mask(cand_mask),
        .cand_sel(cand_sel), .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0),
        .busy(busy), .score_valid(score_valid), .score(score), .score_idx(score_idx),
        .done(done), .winner_valid(winner_valid), .winner(winner), .winner_score(winner_score)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && score_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_score_valid", {score_idx, score}, 64'h0);
            end else begin
                e = sb.pop_front();
                check("score_idx", score_idx, e.idx);
                check("score", score, e.sc);
            end
        end
    end

    task automatic set_slots(input int kind);
        // kind 0: all golden; 1: all zero except slot 5 golden; 2: zero except 1,3 at 60
        for (int i = 0; i < 8; i++) begin
            if (kind == 0 || (kind == 1 && i == 5) || (kind == 2 && (i == 1 || i == 3))) begin
                s_y3[i] = 16'h8000; s_y2[i] = 16'h4C00; s_y1[i] = 16'h6AC0;
                s_y0[i] = (kind == 2) ? 16'hA0AF : 16'hA0A0;
                exp_sc[i] = (kind == 2) ? 7'd60 : 7'd64;
            end else begin
                s_y3[i] = '0; s_y2[i] = '0; s_y1[i] = '0; s_y0[i] = '0;
                exp_sc[i] = 7'd50;
            end
        end
    endtask

    task automatic push_scores(input logic [7:0] mask, input int limit);
        exp_t e;
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i] && n < limit) begin
                e.idx = 3'(i);
                e.sc  = exp_sc[i];
                sb.push_back(e);
                n++;
            end
        end
    endtask

    task automatic run(input string tag, input logic [7:0] mask, input int exp_cycles,
                       input logic exp_wv, input logic [2:0] exp_w, input logic [6:0] exp_ws);
        int n;
        int bad_sel;
        $display("-- %s mask=%02h", tag, mask);
        push_scores(mask, 8);
        @(negedge clk);
        cand_mask = mask;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        bad_sel = 0;
        check({tag, "_winner_cleared"}, winner_valid, 1'b0);
        if (mask != 8'h00) begin
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_vector"}, {a1, a0, b1, b0}, 64'hFF00_F0F0_CCCC_AAAA);
        end
        while (!done && n < 200) begin
            if (busy && !mask[cand_sel]) bad_sel++;
            @(negedge clk);
            n++;
        end
        check({tag, "_done_latency"}, n, exp_cycles);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_bad_cand_sel"}, bad_sel, 0);
        check({tag, "_winner"}, {winner_valid, winner, winner_score}, {exp_wv, exp_w, exp_ws});
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 1'b0);
        check({tag, "_scores_drained"}, sb.size(), 0);
        check({tag, "_winner_held"}, {winner_valid, winner, winner_score}, {exp_wv, exp_w, exp_ws});
    endtask

    initial begin
        int done_seen;
        set_slots(0);
        #1;
        check("reset_vectors", {a1, a0, b1, b0}, 64'h0);
        check("reset_outputs", {cand_sel, busy, score_valid, score, score_idx, done,
                                winner_valid, winner, winner_score}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        set_slots(0);
        run("ideal", 8'hFF, 34, 1'b1, 3'd0, 7'd64);
        set_slots(1);
        run("slot5", 8'hFF, 34, 1'b1, 3'd5, 7'd64);
        run("mask24", 8'h24, 10, 1'b1, 3'd5, 7'd64);
        run("mask0", 8'h00, 2, 1'b0, 3'd0, 7'd0);
        set_slots(2);
        run("tie", 8'hFF, 34, 1'b1, 3'd1, 7'd60);

        // Abort during SETTLE of the third candidate. Its SETTLE spans cycles 9 and 10.
        $display("-- abort");
        set_slots(0);
        push_scores(8'hFF, 2);
        @(negedge clk);
        cand_mask = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_pre_busy", busy, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_winner_valid", winner_valid, 1'b0);
        check("abort_scores_drained", sb.size(), 0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        // Asynchronous reset in the middle of the first candidate's CAPTURE (cycle 3).
        $display("-- reset mid-capture");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_vectors", {a1, a0, b1, b0}, 64'h0);
        check("rst_async_outputs", {cand_sel, busy, score_valid, score, score_idx, done,
                                    winner_valid, winner, winner_score}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("rst_no_done", done_seen, 0);

        run("after_reset", 8'h24, 10, 1'b1, 3'd2, 7'd64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
